narrow_to_wide_fifo: RTL and testbench
======================================

# narrow_to_wide_fifo

Single-clock FIFO that accepts one item per push and releases a group of N_OUT consecutive items per pop. It is the gathering counterpart of the burst-write FIFO. It sits on the consumer side of a lane-serialised stream and packs single elements back into N_OUT-wide beats for wide datapath units. Storage is a circular buffer with wrap-around pointers; non-power-of-two DEPTH is supported.

## Interface
- DATA_WIDTH, 32, width of one item
- DEPTH, 8, storage entries; legal range DEPTH >= 1
- dtype, logic [DATA_WIDTH-1:0], item type
- N_OUT, 4, items released per pop; legal range 1..DEPTH
- ADDR_DEPTH, (DEPTH > 1) ? $clog2(DEPTH) : 1, derived; never overridden
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous clear of pointers and count
- testmode_i  in  1  reserved; no functional effect
- full_o  out  1  status_cnt == DEPTH (cannot accept one item)
- empty_o  out  1  status_cnt < N_OUT (cannot supply a full group)
- usage_o  out  ADDR_DEPTH+1  current occupancy, 0..DEPTH
- data_i  in  dtype  single item to write
- push_i  in  1  write request
- data_o  out  dtype [N_OUT-1:0]  group at head; data_o[0] is oldest
- pop_i  in  1  remove N_OUT items

## Operation
- State consists of rd_ptr and wr_ptr (ADDR_DEPTH bits, range 0..DEPTH-1), status_cnt (ADDR_DEPTH+1 bits), and mem[DEPTH].
- Push takes effect when push_i && !full_o: mem[wr_ptr] <= data_i; wr_ptr advances by 1 and wraps DEPTH-1 -> 0.
- Pop takes effect when pop_i && !empty_o: rd_ptr advances by N_OUT modulo DEPTH.
  - The sum rd_ptr+N_OUT is computed in ADDR_DEPTH+1 bits.
  - If the sum is >= DEPTH, DEPTH is subtracted.
- Count update:
  - push only: +1
  - pop only: -N_OUT
  - both: +1-N_OUT
  - neither: unchanged
- Push while full_o is ignored, even if a pop occurs in the same cycle. Pop while empty_o is ignored. Neither is an error.
- data_o[k] = mem[(rd_ptr+k) mod DEPTH] for k in 0..N_OUT-1. It is combinational from registered state. It is undefined, but stable and X-free after reset, while empty_o is high.
- No fall-through: a pushed item never appears on data_o in the same cycle.
- Priority order: rst_i > flush_i > push/pop.
  - flush_i sets rd_ptr = wr_ptr = status_cnt = 0 and drops any concurrent push or pop.
  - flush_i does not clear mem.
- rst_i clears the pointers, the count, and all mem entries to 0.
- N_OUT == DEPTH is legal: empty_o is high unless the FIFO is completely full.
- N_OUT == 1 degenerates to a plain FIFO.

## Timing
- All outputs are registered-state derived. After a cycle with rst_i high:
  - full_o = 0
  - empty_o = 1 (for N_OUT >= 1)
  - usage_o = 0
  - data_o = all zeros
- Push-to-visible latency is 1 cycle: an item accepted at edge t counts in usage_o and data_o from t+1.
- Pop retires its group at the edge. The next group is presented from that edge onward.
- Flags are Moore-type: full_o and empty_o never depend on push_i or pop_i combinationally.
- The handshake is fire-and-forget. The producer must sample full_o and the consumer must sample empty_o before asserting their request.
- Throughput:
  - 1 item/cycle in
  - 1 group/cycle out when usage >= N_OUT
  - sustained output rate is limited to 1/N_OUT groups per cycle by the input rate

## Test plan
Configuration for all scenarios: DATA_WIDTH=32, DEPTH=8, N_OUT=4.
- Reset: hold rst_i 2 cycles, with push_i=1 during reset -> full_o=0, empty_o=1, usage_o=0, data_o=0. Pushes during reset are discarded.
- Basic gather: push A0,A1,A2,A3 on 4 consecutive cycles.
  - usage_o steps 1,2,3,4.
  - empty_o falls the cycle after A3.
  - data_o={A3,A2,A1,A0}.
  - pop -> usage_o=0, empty_o=1.
- Full: push B0..B7 -> full_o=1, usage_o=8.
  - 9th push B8 is ignored; usage_o stays 8.
  - Two pops yield {B3..B0} then {B7..B4}.
- Wrap-around:
  - push 6 items C0..C5, pop once (rd_ptr=4).
  - push D0..D5 (wr_ptr wraps to 4) -> usage_o=8.
  - pops yield {D1,D0,C5,C4}, then {D5,D4,D3,D2}.
- Simultaneous push+pop at usage 5: usage_o -> 2; the new item is at data_o position 1 after the next 2 pushes fill the group. Push+pop while full is checked as follows:
  - usage 8 -> 4
  - the push is dropped
- Flush and reset mid-operation:
  - at usage 6 with push_i=1 and pop_i=1, assert flush_i -> next cycle usage_o=0, empty_o=1, both requests dropped.
  - repeat the same condition with rst_i instead of flush_i -> identical result, and data_o reads 0 after 4 new pushes overwrite nothing stale.

Source files
------------

// File: rtl/narrow_to_wide_fifo.sv
// Single-clock gathering FIFO: one item enters per push, a group of N_OUT
// consecutive items (oldest in slot 0) leaves per pop. Any DEPTH >= 1 is supported.
module narrow_to_wide_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned N_OUT      = 4,
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              testmode_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [ADDR_DEPTH:0]               usage_o,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic                              push_i,
  output logic [N_OUT-1:0][DATA_WIDTH-1:0]  data_o,
  input  logic                              pop_i
);

  localparam int unsigned CNT_W = ADDR_DEPTH + 1;

  logic [ADDR_DEPTH-1:0] rd_ptr_reg;
  logic [ADDR_DEPTH-1:0] rd_ptr_next;
  logic [ADDR_DEPTH-1:0] wr_ptr_reg;
  logic [ADDR_DEPTH-1:0] wr_ptr_next;
  logic [CNT_W-1:0]      status_cnt_reg;
  logic [CNT_W-1:0]      status_cnt_next;
  logic [CNT_W-1:0]      rd_sum;
  logic                  push_en;
  logic                  pop_en;
  dtype                  mem_reg [DEPTH];

  // testmode_i is reserved and intentionally has no effect.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Flags come only from the registered count, never from the requests.
  assign full_o  = (status_cnt_reg == CNT_W'(DEPTH));
  assign empty_o = (status_cnt_reg <  CNT_W'(N_OUT));
  assign usage_o = status_cnt_reg;

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i  && !empty_o;

  // Read pointer jumps a whole group; the sum is one bit wider so it can exceed DEPTH.
  assign rd_sum = {1'b0, rd_ptr_reg} + CNT_W'(N_OUT);

  always_comb begin
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    status_cnt_next = status_cnt_reg;

    if (flush_i) begin
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      status_cnt_next = '0;
    end else begin
      if (push_en) begin
        if (wr_ptr_reg == ADDR_DEPTH'(DEPTH - 1)) begin
          wr_ptr_next = '0;
        end else begin
          wr_ptr_next = wr_ptr_reg + ADDR_DEPTH'(1);
        end
      end

      if (pop_en) begin
        if (rd_sum >= CNT_W'(DEPTH)) begin
          rd_ptr_next = ADDR_DEPTH'(rd_sum - CNT_W'(DEPTH));
        end else begin
          rd_ptr_next = ADDR_DEPTH'(rd_sum);
        end
      end

      case ({push_en, pop_en})
        2'b10:   status_cnt_next = status_cnt_reg + CNT_W'(1);
        2'b01:   status_cnt_next = status_cnt_reg - CNT_W'(N_OUT);
        2'b11:   status_cnt_next = status_cnt_reg + CNT_W'(1) - CNT_W'(N_OUT);
        default: status_cnt_next = status_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      status_cnt_reg <= '0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      status_cnt_reg <= status_cnt_next;
    end
  end

  // Storage is cleared on reset so data_o is X-free; flush leaves contents alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push_en && !flush_i) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

  // Each output slot reads (rd_ptr + gi) mod DEPTH; gi < DEPTH so one subtraction suffices.
  generate
    for (genvar gi = 0; gi < int'(N_OUT); gi++) begin : g_out
      logic [CNT_W-1:0]      slot_sum;
      logic [ADDR_DEPTH-1:0] slot_idx;

      assign slot_sum = {1'b0, rd_ptr_reg} + CNT_W'(gi);
      assign slot_idx = (slot_sum >= CNT_W'(DEPTH)) ? ADDR_DEPTH'(slot_sum - CNT_W'(DEPTH))
                                                     : ADDR_DEPTH'(slot_sum);
      assign data_o[gi] = mem_reg[slot_idx];
    end
  endgenerate

endmodule

// File: tb/tb_narrow_to_wide_fifo.sv
// Directed bench for narrow_to_wide_fifo (DATA_WIDTH=32, DEPTH=8, N_OUT=4):
// a vector table for the main scenarios plus hand-written multi-cycle sequences.
module tb_narrow_to_wide_fifo;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              testmode;
  logic              full;
  logic              empty;
  logic [3:0]        usage;
  logic [31:0]       din;
  logic              push;
  logic [3:0][31:0]  dout;
  logic              pop;

  int n_checks = 0;
  int n_fail   = 0;

  narrow_to_wide_fifo #(
    .DATA_WIDTH(32),
    .DEPTH(8),
    .N_OUT(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .testmode_i(testmode),
    .full_o(full),
    .empty_o(empty),
    .usage_o(usage),
    .data_i(din),
    .push_i(push),
    .data_o(dout),
    .pop_i(pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         flush;
    logic         push;
    logic         pop;
    logic [31:0]  din;
    int           usage;
    logic         full;
    logic         empty;
    logic         chk;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] tag(input logic [7:0] g, input int i);
    return {g, 24'(i)};
  endfunction

  function automatic logic [127:0] grp(input logic [31:0] d3, input logic [31:0] d2,
                                       input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input string name, input logic r, input logic f,
                              input logic pu, input logic po, input logic [31:0] d,
                              input int u, input logic fu, input logic em,
                              input logic c, input logic [127:0] q);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.din = d;
    v.usage = u; v.full = fu; v.empty = em; v.chk = c; v.dout = q;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Apply one cycle of requests, then sample one time unit after the edge.
  task automatic step(input vec_t v);
    rst = v.rst; flush = v.flush; push = v.push; pop = v.pop; din = v.din;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
    $display("%-10s rst=%0b flush=%0b push=%0b pop=%0b din=%h -> usage=%0d full=%0b empty=%0b dout=%h",
             v.name, v.rst, v.flush, v.push, v.pop, v.din, usage, full, empty, dout);
    check_val({v.name, ".usage"}, 128'(usage), 128'(v.usage));
    check_val({v.name, ".full"},  128'(full),  128'(v.full));
    check_val({v.name, ".empty"}, 128'(empty), 128'(v.empty));
    if (v.chk) check_val({v.name, ".data"}, dout, v.dout);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; testmode = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

    // Reset with a push held high: pushes must be discarded.
    vecs.push_back(mk("rst0", 1, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 1, '0));
    vecs.push_back(mk("rst1", 1, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 1, '0));
    // Basic gather.
    vecs.push_back(mk("A0", 0, 0, 1, 0, tag(8'hA0, 0), 1, 0, 1, 0, '0));
    vecs.push_back(mk("A1", 0, 0, 1, 0, tag(8'hA0, 1), 2, 0, 1, 0, '0));
    vecs.push_back(mk("A2", 0, 0, 1, 0, tag(8'hA0, 2), 3, 0, 1, 0, '0));
    vecs.push_back(mk("A3", 0, 0, 1, 0, tag(8'hA0, 3), 4, 0, 0, 1,
                      grp(tag(8'hA0, 3), tag(8'hA0, 2), tag(8'hA0, 1), tag(8'hA0, 0))));
    vecs.push_back(mk("popA", 0, 0, 0, 1, '0, 0, 0, 1, 0, '0));
    // Fill to full, overflow push ignored, drain in two groups.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk($sformatf("B%0d", i), 0, 0, 1, 0, tag(8'hB0, i), i + 1,
                        (i == 7), (i < 3), (i == 3 || i == 7),
                        grp(tag(8'hB0, 3), tag(8'hB0, 2), tag(8'hB0, 1), tag(8'hB0, 0))));
    end
    vecs.push_back(mk("B8", 0, 0, 1, 0, tag(8'hB0, 8), 8, 1, 0, 1,
                      grp(tag(8'hB0, 3), tag(8'hB0, 2), tag(8'hB0, 1), tag(8'hB0, 0))));
    vecs.push_back(mk("popB0", 0, 0, 0, 1, '0, 4, 0, 0, 1,
                      grp(tag(8'hB0, 7), tag(8'hB0, 6), tag(8'hB0, 5), tag(8'hB0, 4))));
    vecs.push_back(mk("popB1", 0, 0, 0, 1, '0, 0, 0, 1, 0, '0));
    // Flush returns pointers to 0, then the wrap-around scenario.
    vecs.push_back(mk("flush0", 0, 1, 0, 0, '0, 0, 0, 1, 0, '0));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk($sformatf("C%0d", i), 0, 0, 1, 0, tag(8'hC0, i), i + 1,
                        0, (i < 3), (i >= 3),
                        grp(tag(8'hC0, 3), tag(8'hC0, 2), tag(8'hC0, 1), tag(8'hC0, 0))));
    end
    vecs.push_back(mk("popC", 0, 0, 0, 1, '0, 2, 0, 1, 0, '0));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk($sformatf("D%0d", i), 0, 0, 1, 0, tag(8'hD0, i), i + 3,
                        (i == 5), (i < 1), (i >= 1),
                        grp(tag(8'hD0, 1), tag(8'hD0, 0), tag(8'hC0, 5), tag(8'hC0, 4))));
    end
    vecs.push_back(mk("popD0", 0, 0, 0, 1, '0, 4, 0, 0, 1,
                      grp(tag(8'hD0, 5), tag(8'hD0, 4), tag(8'hD0, 3), tag(8'hD0, 2))));
    vecs.push_back(mk("popD1", 0, 0, 0, 1, '0, 0, 0, 1, 0, '0));

    foreach (vecs[i]) step(vecs[i]);

    // Simultaneous push+pop at usage 5; the new item lands in slot 1.
    for (int i = 0; i < 5; i++) begin
      step(mk($sformatf("E%0d", i), 0, 0, 1, 0, tag(8'hE0, i), i + 1, 0, (i < 3), (i == 4),
              grp(tag(8'hE0, 3), tag(8'hE0, 2), tag(8'hE0, 1), tag(8'hE0, 0))));
    end
    step(mk("E5+pop", 0, 0, 1, 1, tag(8'hE0, 5), 2, 0, 1, 0, '0));
    step(mk("E6", 0, 0, 1, 0, tag(8'hE0, 6), 3, 0, 1, 0, '0));
    step(mk("E7", 0, 0, 1, 0, tag(8'hE0, 7), 4, 0, 0, 1,
            grp(tag(8'hE0, 7), tag(8'hE0, 6), tag(8'hE0, 5), tag(8'hE0, 4))));

    // Push+pop while full: pop retires a group, push is dropped.
    for (int i = 0; i < 4; i++) begin
      step(mk($sformatf("F%0d", i), 0, 0, 1, 0, tag(8'hF0, i), i + 5, (i == 3), 0, 1,
              grp(tag(8'hE0, 7), tag(8'hE0, 6), tag(8'hE0, 5), tag(8'hE0, 4))));
    end
    step(mk("F4+pop", 0, 0, 1, 1, tag(8'hF0, 4), 4, 0, 0, 1,
            grp(tag(8'hF0, 3), tag(8'hF0, 2), tag(8'hF0, 1), tag(8'hF0, 0))));
    step(mk("popF", 0, 0, 0, 1, '0, 0, 0, 1, 0, '0));

    // Flush mid-operation with push and pop both asserted.
    for (int i = 0; i < 6; i++) begin
      step(mk($sformatf("G%0d", i), 0, 0, 1, 0, tag(8'h60, i), i + 1, 0, (i < 3), 0, '0));
    end
    step(mk("flush1", 0, 1, 1, 1, tag(8'h60, 6), 0, 0, 1, 0, '0));
    for (int i = 0; i < 4; i++) begin
      step(mk($sformatf("H%0d", i), 0, 0, 1, 0, tag(8'h70, i), i + 1, 0, (i < 3), (i == 3),
              grp(tag(8'h70, 3), tag(8'h70, 2), tag(8'h70, 1), tag(8'h70, 0))));
    end
    step(mk("H4", 0, 0, 1, 0, tag(8'h70, 4), 5, 0, 0, 0, '0));
    step(mk("H5", 0, 0, 1, 0, tag(8'h70, 5), 6, 0, 0, 0, '0));

    // Reset mid-operation: same outcome as flush, plus storage cleared.
    step(mk("rst2", 1, 0, 1, 1, tag(8'h70, 6), 0, 0, 1, 1, '0));
    for (int i = 0; i < 4; i++) begin
      step(mk($sformatf("Z%0d", i), 0, 0, 1, 0, '0, i + 1, 0, (i < 3), 1, '0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
